// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit validation, framing/overflow detection and a FWFT receive FIFO.
// Optional parity stage is compiled in when UART_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 RX,
  input  logic                                 rd_en,
  input  logic                                 clr_err,
  output logic [DATA_W-1:0]                    rx_data,
  output logic                                 rdy,
  output logic                                 full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
  output logic                                 frm_err,
  output logic                                 ovr_err,
  output logic                                 par_err
);

  localparam int unsigned BC_W  = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [BC_W-1:0] HALF_RELOAD = BC_W'(BAUD_DIV / 2 - 1);
  localparam logic [BC_W-1:0] FULL_RELOAD = BC_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [BC_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               frm_err_q, frm_err_d, ovr_err_q, ovr_err_d;
`ifdef UART_PARITY_EN
  logic               par_bad_q, par_bad_d;
  logic               par_err_q, par_err_d;
  logic               par_set;
`endif

  logic expire, push, frm_set, ovr_set, pop, wr, full_c;

  // Receive FSM, synchroniser and FIFO next-state logic
  always_comb begin
    sync1_d   = RX;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frm_set   = 1'b0;
    expire    = (baud_q == '0);
`ifdef UART_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif

    if (state_q != IDLE && !expire) baud_d = baud_q - BC_W'(1);

    case (state_q)
      IDLE: begin
        if (!sync2_q && prev_q) begin
          baud_d  = HALF_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (expire) begin
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            baud_d  = FULL_RELOAD;
            bit_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {sync2_q, shift_q[DATA_W-1:1]};
          baud_d  = FULL_RELOAD;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (expire) begin
          par_bad_d = sync2_q ^ (^shift_q) ^ 1'(PARITY_ODD);
          par_set   = par_bad_d;
          baud_d    = FULL_RELOAD;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          state_d = IDLE;
          if (!sync2_q) frm_set = 1'b1;
`ifdef UART_PARITY_EN
          else if (!par_bad_q) push = 1'b1;
`else
          else push = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle
    full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = rd_en && (count_q != '0);
    wr       = push && (!full_c || pop);
    ovr_set  = push && full_c && !pop;

    mem_d    = mem_q;
    if (wr) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d = wr  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr && pop) count_d = count_q - CNT_W'(1);

    frm_err_d = (clr_err ? 1'b0 : frm_err_q) | frm_set;
    ovr_err_d = (clr_err ? 1'b0 : ovr_err_q) | ovr_set;
`ifdef UART_PARITY_EN
    par_err_d = (clr_err ? 1'b0 : par_err_q) | par_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
`ifdef UART_PARITY_EN
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign rdy     = (count_q != '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign count   = count_q;
  assign rx_data = rdy ? mem_q[rd_ptr_q] : '0;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;
`ifdef UART_PARITY_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DATA_W=8, BAUD_DIV=16, FIFO_DEPTH=4).
module tb_uart_rx_fifo;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BAUD_DIV   = 16;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned LAT_MAX = 3 + (DATA_W + 1) * BAUD_DIV + BAUD_DIV / 2 + 1 + PAR_BITS * BAUD_DIV;
  // Negedge count from the start-bit edge to the cycle whose posedge pushes the frame
  localparam int unsigned PUSH_AT = 155 + PAR_BITS * BAUD_DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx = 1'b1;
  logic              rd_en = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rdy, full, frm_err, ovr_err, par_err;
  logic [2:0]        count;
`ifdef UART_PARITY_EN
  logic              par_flip = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(DATA_W), .BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .RX(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rdy(rdy), .full(full), .count(count),
    .frm_err(frm_err), .ovr_err(ovr_err), .par_err(par_err)
  );

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_PARITY_EN
    hold_bit((^d) ^ par_flip);
`endif
    hold_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 3'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (frm_err !== 1'b0 || ovr_err !== 1'b0 || par_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs got %b%b%b exp 000", frm_err, ovr_err, par_err);
    end
  endtask

  task automatic test_single_byte();
    int lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge clk);
        while (!rdy && lat < 300) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++; if (lat > int'(LAT_MAX)) begin errors++; $display("FAIL single_latency got %0d exp <= %0d", lat, LAT_MAX); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", rx_data); end
    checks++; if (count !== 3'd1 || rdy !== 1'b1) begin errors++; $display("FAIL single_count got %0d/%b exp 1/1", count, rdy); end
    pop_one();
    checks++; if (rdy !== 1'b0 || rx_data !== 8'h00 || count !== 3'd0) begin
      errors++; $display("FAIL single_pop got rdy=%b data=%h count=%0d exp 0/00/0", rdy, rx_data, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovr_full got %b/%0d exp 1/4", full, count); end
    checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", ovr_err); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rx_data !== 8'(i)) begin errors++; $display("FAIL ovr_read%0d got %h exp %h", i, rx_data, 8'(i)); end
      pop_one();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL ovr_drain got %0d exp 0", count); end
    pulse_clr();
    checks++; if (ovr_err !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr_err); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pp_prefill got %b exp 1", full); end
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (PUSH_AT) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (count !== 3'd4 || ovr_err !== 1'b0) begin
          errors++; $display("FAIL pp_same_cycle got count=%0d ovr=%b exp 4/0", count, ovr_err);
        end
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_data !== exp_q[i]) begin errors++; $display("FAIL pp_read%0d got %h exp %h", i, rx_data, exp_q[i]); end
      pop_one();
    end
    checks++; if (ovr_err !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL pp_end got ovr=%b count=%0d exp 0/0", ovr_err, count); end
  endtask

  task automatic test_false_start_framing();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (count !== 3'd0 || frm_err !== 1'b0) begin errors++; $display("FAIL glitch got count=%0d frm=%b exp 0/0", count, frm_err); end
    send_frame(8'h3C, 1'b0);
    repeat (16) @(negedge clk);
    checks++; if (frm_err !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL frame_err got frm=%b count=%0d exp 1/0", frm_err, count); end
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h81 || count !== 3'd1) begin errors++; $display("FAIL after_frm got %h/%0d exp 81/1", rx_data, count); end
    checks++; if (frm_err !== 1'b1) begin errors++; $display("FAIL frm_sticky got %b exp 1", frm_err); end
    pop_one();
    pulse_clr();
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL frm_clear got %b exp 0", frm_err); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h99, 1'b1);
    send_frame(8'h3C, 1'b0);
    repeat (16) @(negedge clk);
    checks++; if (count !== 3'd1 || frm_err !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b exp 1/1", count, frm_err); end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (86) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rdy !== 1'b0 || count !== 3'd0 || rx_data !== 8'h00 || full !== 1'b0) begin
          errors++; $display("FAIL mid_reset_fifo got rdy=%b count=%0d data=%h full=%b exp 0/0/00/0", rdy, count, rx_data, full);
        end
        checks++; if (frm_err !== 1'b0 || ovr_err !== 1'b0 || par_err !== 1'b0) begin
          errors++; $display("FAIL mid_reset_errs got %b%b%b exp 000", frm_err, ovr_err, par_err);
        end
      end
    join
    repeat (8) @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_no_partial got %0d exp 0", count); end
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h7E || count !== 3'd1) begin errors++; $display("FAIL mid_next got %h/%0d exp 7e/1", rx_data, count); end
    pop_one();
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    par_flip = 1'b0;
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h0F || count !== 3'd1 || par_err !== 1'b0) begin
      errors++; $display("FAIL par_good got %h/%0d/%b exp 0f/1/0", rx_data, count, par_err);
    end
    pop_one();
    par_flip = 1'b1;
    send_frame(8'h0F, 1'b1);
    par_flip = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (count !== 3'd0 || par_err !== 1'b1) begin errors++; $display("FAIL par_bad got %0d/%b exp 0/1", count, par_err); end
    pulse_clr();
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_push_pop_full();
    test_false_start_framing();
    test_reset_midframe();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
